// File: rtl/icache_pkg.sv
// Shared types and width helpers for the instruction cache fetch unit.
package icache_pkg;

    localparam int ADDR_W = 16;
    localparam logic [15:0] NOP = 16'h0000;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fetch_state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int line_words);
        return ADDR_W - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_fetch_unit_if.sv
// Read port between the fetch unit and the backing instruction memory.
interface icache_fetch_unit_if;
    logic        req;
    logic [15:0] addr;
    logic [15:0] rdata;
    logic        ack;

    modport master (output req, output addr, input rdata, input ack);
    modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache. Only valid bits are reset.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    localparam int OFF_W     = off_w(LINE_WORDS),
    localparam int IDX_W     = idx_w(LINES),
    localparam int TAG_W     = tag_w(LINES, LINE_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [15:0]      rd_data,
    input  logic             word_wr,
    input  logic [IDX_W-1:0] word_idx,
    input  logic [OFF_W-1:0] word_off,
    input  logic [15:0]      word_data,
    input  logic             tag_wr,
    input  logic [IDX_W-1:0] tag_idx,
    input  logic [TAG_W-1:0] tag_val,
    input  logic             tag_valid_set
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [15:0]      data_mem [LINES][LINE_WORDS];

    // Valid bits: flush wins over a simultaneous line completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (tag_wr) begin
            valid[tag_idx] <= tag_valid_set;
        end
    end

    // Tag and data storage, deliberately without reset.
    always_ff @(posedge clk) begin
        if (tag_wr) begin
            tag_mem[tag_idx] <= tag_val;
        end
        if (word_wr) begin
            data_mem[word_idx][word_off] <= word_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx][rd_off];

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped read-only instruction cache: combinational hit path,
// whole-line refill over a req/ack memory port on a miss.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | lookup active; a miss latches the line and starts a refill
//   FILL  | fetching words 0..LINE_WORDS-1 of the latched line, one per ack
module icache_fetch_unit
    import icache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_addr,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [15:0] instr,
    output logic        icache_stall,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
    icache_fetch_unit_if.master mem
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(LINES);
    localparam int TAG_W  = tag_w(LINES, LINE_WORDS);
    localparam int LINE_W = ADDR_W - OFF_W;

    fetch_state_t state, state_next;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] fill_line;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [OFF_W-1:0]  k;
    logic              flush_pend;
    logic              req_reg;
    logic [15:0]       addr_reg;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [15:0]       rd_data;

    logic              hit;
    logic              start_fill;
    logic              word_wr;
    logic              last_ack;
    logic              ack_ok;

    assign off      = pc_addr[OFF_W-1:0];
    assign idx      = pc_addr[OFF_W +: IDX_W];
    assign tag      = pc_addr[ADDR_W-1 -: TAG_W];
    assign fill_idx = fill_line[IDX_W-1:0];
    assign fill_tag = fill_line[LINE_W-1:IDX_W];

    // An ack only counts while a request is actually outstanding.
    assign ack_ok = req_reg && mem.ack && reset;

    icache_line_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_lines (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .rd_idx        (idx),
        .rd_off        (off),
        .rd_valid      (rd_valid),
        .rd_tag        (rd_tag),
        .rd_data       (rd_data),
        .word_wr       (word_wr),
        .word_idx      (fill_idx),
        .word_off      (k),
        .word_data     (mem.rdata),
        .tag_wr        (last_ack),
        .tag_idx       (fill_idx),
        .tag_val       (fill_tag),
        .tag_valid_set (!flush_pend && !flush)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, hit detection and fill-progress strobes.
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        start_fill = 1'b0;
        word_wr    = 1'b0;
        last_ack   = 1'b0;
        case (state)
            IDLE: begin
                hit = rd_valid && (rd_tag == tag);
                if (!hit) begin
                    start_fill = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (ack_ok) begin
                    word_wr = 1'b1;
                    if (k == OFF_W'(LINE_WORDS - 1)) begin
                        last_ack   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fill bookkeeping and the registered memory request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_line  <= '0;
            k          <= '0;
            flush_pend <= 1'b0;
            req_reg    <= 1'b0;
            addr_reg   <= '0;
        end else begin
            if (start_fill) begin
                fill_line <= pc_addr[ADDR_W-1:OFF_W];
                k         <= '0;
                req_reg   <= 1'b1;
                addr_reg  <= {pc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end else if (word_wr) begin
                if (last_ack) begin
                    k       <= '0;
                    req_reg <= 1'b0;
                end else begin
                    k        <= k + OFF_W'(1);
                    addr_reg <= {fill_line, k + OFF_W'(1)};
                end
            end
            if (start_fill || last_ack) begin
                flush_pend <= 1'b0;
            end else if (state == FILL && flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // Saturating hit/miss statistics; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && fetch_en && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (start_fill && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign instr        = hit ? rd_data : NOP;
    assign icache_stall = !hit;
    assign mem.req      = req_reg;
    assign mem.addr     = addr_reg;

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Scoreboard bench for icache_fetch_unit with a line-residency reference model.
module tb_icache_fetch_unit;

    localparam int LINES      = 16;
    localparam int LINE_WORDS = 4;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc_addr = 16'h0000;
    logic        fetch_en = 1'b0;
    logic        flush;
    logic [15:0] instr;
    logic        icache_stall;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    icache_fetch_unit_if mem_bus ();

    icache_fetch_unit #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_addr      (pc_addr),
        .fetch_en     (fetch_en),
        .flush        (flush),
        .instr        (instr),
        .icache_stall (icache_stall),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
        .mem          (mem_bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [15:0] addr_log[$];
    int          resident[LINES];
    int          exp_hits = 0;
    int          exp_miss = 0;
    int          mem_lat = 1;
    int          lat_cnt = 0;
    int          ack_total = 0;
    int          flush_on_ack = 0;
    bit          flush_req = 0;
    bit          inj_ack = 0;
    bit          fetch_active = 0;
    bit          fetch_done = 0;
    int          stall_run = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) resident[i] = -1;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // Drive one fetch at posedge+1; returns at posedge+1 after its hit cycle.
    task automatic do_fetch(input logic [15:0] pc, input logic en, input int lat, input bit flush_mid);
        exp_t e;
        int   line;
        int   slot;
        int   pen;
        int   n;
        line = int'(pc) / LINE_WORDS;
        slot = line % LINES;
        pen  = 1 + LINE_WORDS * (lat + 1);
        e.pc    = pc;
        e.instr = mem_word(pc);
        if (resident[slot] == line) begin
            e.stalls = 0;
        end else if (flush_mid) begin
            for (int i = 0; i < LINES; i++) resident[i] = -1;
            e.stalls = 2 * pen;
            exp_miss += 2;
            resident[slot] = line;
        end else begin
            e.stalls = pen;
            exp_miss += 1;
            resident[slot] = line;
        end
        if (en && exp_hits < 65535) exp_hits++;
        exp_q.push_back(e);
        mem_lat = lat;
        if (flush_mid) flush_on_ack = 3;
        pc_addr      = pc;
        fetch_en     = en;
        fetch_done   = 0;
        fetch_active = 1;
        n = 0;
        while (!fetch_done) begin
            @(posedge clk);
            n++;
            if (n > 400) begin
                checks++;
                errors++;
                $display("FAIL fetch_timeout pc=%h: no hit after %0d cycles", pc, n);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
        #1;
        fetch_active = 0;
    endtask

    // Backing memory: ack after mem_lat idle cycles per word, plus flush/late-ack injection.
    initial begin
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = 16'h0000;
        flush         = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mem_bus.ack = 1'b0;
            flush       = 1'b0;
            if (flush_req) begin
                flush     = 1'b1;
                flush_req = 0;
            end
            if (inj_ack) begin
                mem_bus.ack   = 1'b1;
                mem_bus.rdata = 16'hDEAD;
                inj_ack       = 0;
                lat_cnt       = 0;
            end else if (mem_bus.req) begin
                if (lat_cnt >= mem_lat) begin
                    mem_bus.ack   = 1'b1;
                    mem_bus.rdata = mem_word(mem_bus.addr);
                    lat_cnt       = 0;
                    ack_total++;
                    if (flush_on_ack > 0) begin
                        flush_on_ack--;
                        if (flush_on_ack == 0) flush = 1'b1;
                    end
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: counts stall cycles of the active fetch and scores its delivered word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_bus.req && mem_bus.ack) addr_log.push_back(mem_bus.addr);
            if (fetch_active && !fetch_done) begin
                if (icache_stall) begin
                    stall_run++;
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: instr %h with empty scoreboard", instr);
                    end else begin
                        e = exp_q.pop_front();
                        checks += 2;
                        if (instr !== e.instr) begin
                            errors++;
                            $display("FAIL instr pc=%h: got %h, expected %h", e.pc, instr, e.instr);
                        end
                        if (stall_run != e.stalls) begin
                            errors++;
                            $display("FAIL stall_cycles pc=%h: got %0d, expected %0d", e.pc, stall_run, e.stalls);
                        end
                    end
                    stall_run  = 0;
                    fetch_done = 1;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [15:0] pc;
        int          base;
        int          n;
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {15'b0, icache_stall}, 16'h0001);
        chk("reset_instr", instr, 16'h0000);
        chk("reset_mem_req", {15'b0, mem_bus.req}, 16'h0000);
        chk("reset_mem_addr", mem_bus.addr, 16'h0000);
        chk("reset_hit_cnt", hit_cnt, 16'h0000);
        chk("reset_miss_cnt", miss_cnt, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Cold miss at 0x0000 with 1-cycle ack latency.
        addr_log.delete();
        do_fetch(16'h0000, 1'b1, 1, 0);
        chk("fill_addr_count", 16'(addr_log.size()), 16'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("fill_addr", addr_log[i], 16'(i));
        chk("miss_cnt_t1", miss_cnt, 16'd1);

        // Same-line hits.
        for (int i = 1; i < 4; i++) do_fetch(16'(i), 1'b1, 1, 0);
        chk("hit_cnt_t2", hit_cnt, 16'd4);

        // Conflict miss on index 0.
        do_fetch(16'h0040, 1'b1, 1, 0);
        do_fetch(16'h0000, 1'b1, 1, 0);
        chk("miss_cnt_t3", miss_cnt, 16'd3);

        // Flush during the third ack of a fill: line not validated, refetch misses.
        do_fetch(16'h0010, 1'b1, 1, 1);
        chk("miss_cnt_t4", miss_cnt, 16'd5);

        // Reset during the second word of a fill, followed by a stray ack.
        mem_lat  = 2;
        pc_addr  = 16'h0030;
        fetch_en = 1'b1;
        base     = ack_total;
        n        = 0;
        while (ack_total == base && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("t5_first_ack_seen", 16'(ack_total - base), 16'd1);
        #1;
        reset   = 1'b0;
        inj_ack = 1;
        @(posedge clk);
        #1;
        chk("t5_mem_req", {15'b0, mem_bus.req}, 16'h0000);
        chk("t5_stall", {15'b0, icache_stall}, 16'h0001);
        chk("t5_miss_cnt", miss_cnt, 16'h0000);
        chk("t5_hit_cnt", hit_cnt, 16'h0000);
        reset = 1'b1;
        model_reset();
        do_fetch(16'h0030, 1'b1, 2, 0);
        chk("t5_miss_after", miss_cnt, 16'd1);

        // Randomized fetch stream with occasional whole-cache flushes.
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 15) == 0) begin
                fetch_en  = 1'b0;
                flush_req = 1;
                @(posedge clk);
                #1;
                for (int i = 0; i < LINES; i++) resident[i] = -1;
            end
            pc = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) pc[15:12] = 4'hF;
            do_fetch(pc, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
        end
        chk("rand_hit_cnt", hit_cnt, 16'(exp_hits));
        chk("rand_miss_cnt", miss_cnt, 16'(exp_miss));

        // Hit counter saturation.
        do_fetch(16'h0020, 1'b1, 0, 0);
        pc_addr  = 16'h0020;
        fetch_en = 1'b1;
        repeat (65600) @(posedge clk);
        #1;
        chk("sat_hit_cnt", hit_cnt, 16'hFFFF);
        chk("sat_instr", instr, mem_word(16'h0020));
        repeat (10) @(posedge clk);
        #1;
        chk("sat_hit_hold", hit_cnt, 16'hFFFF);
        chk("sat_miss_cnt", miss_cnt, 16'(exp_miss));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
